systolic_mem_responder: RTL and testbench
=========================================

SYSTOLIC_MEM_RESPONDER -- requirements
Module: systolic_mem_responder

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of words stored; 1 <= DEPTH <= 4096.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 act_addr  input  12  NPU word address.
REQ-006 mem_write  input  1  NPU write strobe.
REQ-007 mem_data_write  input  WIDTH signed  NPU write data.
REQ-008 mem_read  output  WIDTH signed  NPU read data.
REQ-009 npu_active  input  1  NPU owns memory while high.
REQ-010 host_req  input  1  host access request.
REQ-011 host_we  input  1  host write when 1, read when 0.
REQ-012 host_addr  input  12  host word address.
REQ-013 host_wdata  input  WIDTH signed  host write data.
REQ-014 host_gnt  output  1  host request accepted this cycle.
REQ-015 host_rvalid  output  1  host read data valid.
REQ-016 host_rdata  output  WIDTH signed  host read data.
REQ-017 owner  output  2  current owner state (mem_owner_t).
REQ-018 served_reads  output  32  NPU read count.
REQ-019 served_writes  output  32  NPU write count.
REQ-020 addr_error  output  1  sticky out-of-range flag.

Function
REQ-021 States: IDLE, NPU_OWN, DRAIN, HOST_OWN; state drives owner.
REQ-022 IDLE: npu_active=1 -> NPU_OWN (priority over host); else host_req=1 -> HOST_OWN; else stay.
REQ-023 NPU_OWN: every cycle reads mem[act_addr]; mem_read valid exactly 1 cycle after address presented; served_reads +1 per cycle with mem_write=0.
REQ-024 NPU_OWN with mem_write=1: mem[act_addr] <= mem_data_write at that edge; served_writes +1; mem_read next cycle returns new data (write-first).
REQ-025 npu_active falling in NPU_OWN -> DRAIN for exactly 1 cycle, still honouring an NPU write that cycle, then IDLE.
REQ-026 HOST_OWN: host_gnt=host_req combinationally; granted write updates memory at edge; granted read gives host_rdata with host_rvalid=1 exactly 1 cycle later, else host_rvalid=0.
REQ-027 HOST_OWN: npu_active=1 -> NPU_OWN next cycle, host_gnt forced 0 that cycle; host_req=0 with npu_active=0 -> IDLE.
REQ-028 host_gnt=0 in IDLE, NPU_OWN, DRAIN; NPU strobes ignored outside NPU_OWN/DRAIN.
REQ-029 mem_read holds last value when not in NPU_OWN/DRAIN; host_rdata holds between valid pulses.
REQ-030 Counters wrap at 2^32 silently; simultaneous rst wins over any access.

Reset
REQ-031 rst=1: state IDLE; mem_read, host_rdata, host_rvalid, host_gnt, served_reads, served_writes, addr_error all 0.
REQ-032 Memory contents are not reset; rst mid-write discards that write; rst mid-host-read drops pending host_rvalid.

Configuration
REQ-033 Macro MEM_BOUNDS_CHECK_EN defined: any access with address >= DEPTH is suppressed (no write, read returns 0), sets addr_error until rst, still counted.
REQ-034 Macro MEM_BOUNDS_CHECK_EN undefined: address used modulo DEPTH, addr_error tied 0.

Structure
REQ-035 SystolicTypes package holds mem_owner_t enum (IDLE=0, NPU_OWN=1, DRAIN=2, HOST_OWN=3) and MEM_DEPTH default constant.
REQ-036 One sub-module mem_array: single-port synchronous RAM, WIDTH x DEPTH, registered read, write-first; arbitration mux and FSM live in systolic_mem_responder.

Verification
REQ-037 Host writes 0x0011 to addr 5 in HOST_OWN, then reads addr 5 -> host_gnt=1 both, host_rvalid=1 with host_rdata=0x0011 one cycle after read.
REQ-038 npu_active=1, act_addr=5 -> owner=NPU_OWN next cycle, mem_read=0x0011 one cycle after address, served_reads=1.
REQ-039 NPU writes -7 to addr 20, npu_active drops same cycle -> DRAIN 1 cycle then IDLE; host read addr 20 returns -7 (0xFFF9), served_writes=1.
REQ-040 host_req held while npu_active rises -> host_gnt=0 during NPU_OWN/DRAIN, host serviced in cycle after IDLE re-entered.
REQ-041 With MEM_BOUNDS_CHECK_EN, DEPTH=1024, NPU write to addr 1030 -> addr 6 unchanged, addr_error=1 until rst; without macro, addr 6 written.
REQ-042 rst asserted mid-NPU-burst -> all outputs 0 same cycle, owner IDLE, previously written addresses retain data.

Source files
------------

// File: rtl/systolic_mem_responder_pkg.sv
// systolic_mem_responder_pkg: shared ownership states and default memory depth
package systolic_mem_responder_pkg;

    localparam int MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        NPU_OWN  = 2'd1,
        DRAIN    = 2'd2,
        HOST_OWN = 2'd3
    } mem_owner_t;

endpackage

// File: rtl/systolic_mem_responder_mem_array.sv
// systolic_mem_responder_mem_array: single-port synchronous RAM, registered read, write-first
module systolic_mem_responder_mem_array
    import systolic_mem_responder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // One access per enabled cycle; a write returns its own data on the read port
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/systolic_mem_responder.sv
// systolic_mem_responder: NPU/host memory arbiter; MEM_BOUNDS_CHECK_EN enables out-of-range suppression
module systolic_mem_responder
    import systolic_mem_responder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             act_addr,
    input  logic                    mem_write,
    input  logic signed [WIDTH-1:0] mem_data_write,
    output logic signed [WIDTH-1:0] mem_read,
    input  logic                    npu_active,
    input  logic                    host_req,
    input  logic                    host_we,
    input  logic [11:0]             host_addr,
    input  logic signed [WIDTH-1:0] host_wdata,
    output logic                    host_gnt,
    output logic                    host_rvalid,
    output logic signed [WIDTH-1:0] host_rdata,
    output logic [1:0]              owner,
    output logic [31:0]             served_reads,
    output logic [31:0]             served_writes,
    output logic                    addr_error
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_owner_t state, state_nx;
    logic npu_acc, en, we, oob, oob_q, npu_rv;
    logic [11:0] addr;
    logic [AW-1:0] ram_addr;
    logic signed [WIDTH-1:0] wdata, ram_q, rd, npu_hold, host_hold;

    // Ownership transitions plus who may touch the RAM this cycle
    always_comb begin
        state_nx = state;
        npu_acc  = state == NPU_OWN || state == DRAIN;
        host_gnt = state == HOST_OWN && host_req && !npu_active;
        case (state)
            IDLE:     state_nx = npu_active ? NPU_OWN : host_req ? HOST_OWN : IDLE;
            NPU_OWN:  state_nx = npu_active ? NPU_OWN : DRAIN;
            DRAIN:    state_nx = IDLE;
            HOST_OWN: state_nx = npu_active ? NPU_OWN : host_req ? HOST_OWN : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign addr     = npu_acc ? act_addr : host_addr;
    assign wdata    = npu_acc ? mem_data_write : host_wdata;
    assign en       = npu_acc || host_gnt;
    assign ram_addr = AW'({1'b0, addr} % 13'(DEPTH));

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = en && ({1'b0, addr} >= 13'(DEPTH));
`else
    assign oob = 1'b0;
`endif

    // Reset forces IDLE asynchronously, so no access (and no write) survives an asserted rst
    assign we         = (npu_acc ? mem_write : host_gnt && host_we) && !oob;
    assign rd         = oob_q ? '0 : ram_q;
    assign mem_read   = npu_rv ? rd : npu_hold;
    assign host_rdata = host_rvalid ? rd : host_hold;
    assign owner      = state;

    systolic_mem_responder_mem_array #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .en   (en),
        .we   (we),
        .addr (ram_addr),
        .wdata(wdata),
        .rdata(ram_q)
    );

    // State, read-valid tracking, held read data, NPU counters and sticky range error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            npu_rv        <= 1'b0;
            host_rvalid   <= 1'b0;
            oob_q         <= 1'b0;
            npu_hold      <= '0;
            host_hold     <= '0;
            served_reads  <= '0;
            served_writes <= '0;
            addr_error    <= 1'b0;
        end else begin
            state       <= state_nx;
            npu_rv      <= npu_acc;
            host_rvalid <= host_gnt && !host_we;
            oob_q       <= oob;
            npu_hold    <= mem_read;
            host_hold   <= host_rdata;
            if (npu_acc && mem_write) served_writes <= served_writes + 32'd1;
            if (npu_acc && !mem_write) served_reads <= served_reads + 32'd1;
            addr_error  <= addr_error || oob;
        end
    end

endmodule

// File: tb/tb_systolic_mem_responder.sv
// tb_systolic_mem_responder: table-driven arbiter bench with NPU/host read scoreboards
module tb_systolic_mem_responder;

    localparam int DEPTH = 1024;
    localparam int ID = 0, NP = 1, DR = 2, HO = 3;

    typedef struct {
        logic [1:0]  owner;
        logic        gnt;
        logic        na;
        logic [11:0] aa;
        logic        mw;
        logic [15:0] md;
        logic        hr;
        logic        hw;
        logic [11:0] ha;
        logic [15:0] hd;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] act_addr = '0, host_addr = '0;
    logic        mem_write = 1'b0, npu_active = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [15:0] mem_data_write = '0, host_wdata = '0;
    logic [15:0] mem_read, host_rdata;
    logic        host_gnt, host_rvalid, addr_error;
    logic [1:0]  owner;
    logic [31:0] served_reads, served_writes;

    int checks = 0, errors = 0;
    logic [15:0] mm [int];
    logic [15:0] nq [$];
    logic [15:0] hq [$];
    logic [15:0] exp_mr = '0, exp_hr = '0;
    int exp_reads = 0, exp_writes = 0;
    logic exp_err = 1'b0;
    vec_t vt [$];

    always #5 clk = ~clk;

    systolic_mem_responder #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .act_addr(act_addr), .mem_write(mem_write),
        .mem_data_write(mem_data_write), .mem_read(mem_read), .npu_active(npu_active),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .owner(owner),
        .served_reads(served_reads), .served_writes(served_writes), .addr_error(addr_error)
    );

    function automatic vec_t mk(int o, int g, int na, int aa, int mw, int md, int hr, int hw, int ha, int hd);
        vec_t t;
        t.owner = 2'(o); t.gnt = 1'(g); t.na = 1'(na); t.aa = 12'(aa); t.mw = 1'(mw);
        t.md = 16'(md); t.hr = 1'(hr); t.hw = 1'(hw); t.ha = 12'(ha); t.hd = 16'(hd);
        return t;
    endfunction

    function automatic logic oob(logic [11:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask

    task automatic drive(vec_t t);
        npu_active = t.na; act_addr = t.aa; mem_write = t.mw; mem_data_write = t.md;
        host_req = t.hr; host_we = t.hw; host_addr = t.ha; host_wdata = t.hd;
    endtask

    task automatic clear_model();
        nq.delete(); hq.delete();
        exp_mr = '0; exp_hr = '0; exp_reads = 0; exp_writes = 0; exp_err = 1'b0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
        chk({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
        chk({tag, "_host_gnt"}, 32'(host_gnt), 32'd0);
        chk({tag, "_reads"}, served_reads, 32'd0);
        chk({tag, "_writes"}, served_writes, 32'd0);
        chk({tag, "_addr_error"}, 32'(addr_error), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'(ID));
    endtask

    // One cycle: drive, check last edge's results and this cycle's combinational outputs, then model
    task automatic apply(vec_t t);
        int k;
        logic o;
        @(posedge clk);
        #1;
        drive(t);
        @(negedge clk);
        chk("host_rvalid", 32'(host_rvalid), 32'(hq.size() > 0));
        if (hq.size() > 0) exp_hr = hq.pop_front();
        chk("host_rdata", 32'(host_rdata), 32'(exp_hr));
        if (nq.size() > 0) exp_mr = nq.pop_front();
        chk("mem_read", 32'(mem_read), 32'(exp_mr));
        chk("served_reads", served_reads, 32'(exp_reads));
        chk("served_writes", served_writes, 32'(exp_writes));
        chk("addr_error", 32'(addr_error), 32'(exp_err));
        chk("owner", 32'(owner), 32'(t.owner));
        chk("host_gnt", 32'(host_gnt), 32'(t.gnt));
        if (t.owner == 2'(NP) || t.owner == 2'(DR)) begin
            o = oob(t.aa);
            k = int'(t.aa) % DEPTH;
            exp_err |= o;
            if (t.mw) begin
                exp_writes++;
                if (!o) mm[k] = t.md;
            end else exp_reads++;
            nq.push_back(o ? 16'h0 : mm[k]);
        end else if (t.gnt) begin
            o = oob(t.ha);
            k = int'(t.ha) % DEPTH;
            exp_err |= o;
            if (t.hw) begin
                if (!o) mm[k] = t.hd;
            end else hq.push_back(o ? 16'h0 : mm[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //            owner gnt na  aa  mw  md      hr hw ha  hd
        vt.push_back(mk(ID, 0, 0, 5,    1, 'h99,   0, 0, 0,  0));
        vt.push_back(mk(ID, 0, 0, 0,    0, 0,      1, 1, 5,  'h11));
        vt.push_back(mk(HO, 1, 0, 0,    0, 0,      1, 1, 5,  'h11));
        vt.push_back(mk(HO, 1, 0, 0,    0, 0,      1, 0, 5,  0));
        vt.push_back(mk(HO, 0, 0, 5,    1, 'h99,   0, 0, 0,  0));
        vt.push_back(mk(ID, 0, 1, 5,    0, 0,      0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 1, 5,    0, 0,      0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 0, 20,   1, -7,     0, 0, 0,  0));
        vt.push_back(mk(DR, 0, 0, 21,   1, 'h123,  0, 0, 0,  0));
        vt.push_back(mk(ID, 0, 0, 0,    0, 0,      1, 0, 20, 0));
        vt.push_back(mk(HO, 1, 0, 0,    0, 0,      1, 0, 20, 0));
        vt.push_back(mk(HO, 1, 0, 0,    0, 0,      1, 0, 21, 0));
        vt.push_back(mk(HO, 0, 1, 21,   0, 0,      1, 1, 21, 'h55));
        vt.push_back(mk(NP, 0, 1, 21,   0, 0,      1, 1, 21, 'h55));
        vt.push_back(mk(NP, 0, 0, 21,   0, 0,      1, 0, 21, 0));
        vt.push_back(mk(DR, 0, 0, 21,   0, 0,      1, 1, 22, 'h2222));
        vt.push_back(mk(ID, 0, 0, 0,    0, 0,      1, 1, 22, 'h2222));
        vt.push_back(mk(HO, 1, 0, 0,    0, 0,      1, 1, 22, 'h2222));
        vt.push_back(mk(HO, 1, 0, 0,    0, 0,      1, 0, 22, 0));
        vt.push_back(mk(HO, 0, 0, 0,    0, 0,      0, 0, 0,  0));
        vt.push_back(mk(ID, 0, 1, 0,    0, 0,      0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 1, 6,    1, 'h600,  0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 1, 1030, 1, 'hBAD,  0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 1, 6,    0, 0,      0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 1, 1023, 1, 'h3FF,  0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 1, 1023, 0, 0,      0, 0, 0,  0));
        vt.push_back(mk(NP, 0, 0, 4095, 0, 0,      0, 0, 0,  0));
        vt.push_back(mk(DR, 0, 0, 1023, 0, 0,      0, 0, 0,  0));
        vt.push_back(mk(ID, 0, 0, 0,    0, 0,      0, 0, 0,  0));
        vt.push_back(mk(ID, 0, 0, 0,    0, 0,      0, 0, 0,  0));

        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vt[i]) apply(vt[i]);

        // Reset in the middle of an NPU write burst
        apply(mk(ID, 0, 1, 0,  0, 0,     0, 0, 0, 0));
        apply(mk(NP, 0, 1, 40, 1, 'h40,  0, 0, 0, 0));
        apply(mk(NP, 0, 1, 41, 1, 'h41,  0, 0, 0, 0));
        apply(mk(NP, 0, 1, 41, 0, 0,     0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(mk(NP, 0, 1, 41, 1, 'hDEAD, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_npu");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        clear_model();
        apply(mk(ID, 0, 0, 0, 0, 0, 1, 0, 41, 0));
        apply(mk(HO, 1, 0, 0, 0, 0, 1, 0, 41, 0));
        apply(mk(HO, 1, 0, 0, 0, 0, 1, 0, 40, 0));
        apply(mk(HO, 0, 0, 0, 0, 0, 0, 0, 0,  0));
        apply(mk(ID, 0, 0, 0, 0, 0, 0, 0, 0,  0));

        // Reset while a granted host read is pending
        apply(mk(ID, 0, 0, 0, 0, 0, 1, 0, 40, 0));
        apply(mk(HO, 1, 0, 0, 0, 0, 1, 0, 40, 0));
        rst = 1'b1;
        host_req = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_host");
        rst = 1'b0;
        clear_model();
        apply(mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        chk("queues_drained", 32'(nq.size() + hq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
